pause_dim: RTL and testbench
============================

PAUSE_DIM -- requirements
Module: pause_dim

Interface
REQ-001 SHALL have parameter DIM_FRAMES, default 600, meaning paused frames before dimming begins (16-bit range, 1..65535).
REQ-002 SHALL have parameter FADE_FRAMES, default 8, meaning frames between successive fade levels (1..255).
REQ-003 SHALL have port clk  input  1  single clock for all logic (video clock domain).
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port pause_btn  input  1  user pause button, level, already synchronous to clk.
REQ-006 SHALL have port pause_req  input  1  external forced pause (OSD / hiscore access), level.
REQ-007 SHALL have port vblank  input  1  vertical blank from core, synchronous to clk.
REQ-008 SHALL have port rgb_in  input  12  core pixel {r[3:0],g[3:0],b[3:0]}.
REQ-009 SHALL have port rgb_out  output  12  shaded pixel to video output stage.
REQ-010 SHALL have port pause  output  1  pause to core, active-high.
REQ-011 SHALL have port dimmed  output  1  high while shade level is non-zero.

Function
REQ-012 SHALL toggle an internal user-pause flag on each rising edge of pause_btn, detected against a registered previous value.
REQ-013 SHALL drive pause = user-pause flag OR pause_req, registered, one-cycle latency.
REQ-014 SHALL implement states RUN, PAUSED, FADING, DIMMED.
REQ-015 RUN->PAUSED when pause goes high; frame counter cleared; level 0.
REQ-016 PAUSED: count vblank rising edges; on count reaching DIM_FRAMES go to FADING (fade build) or DIMMED (non-fade build).
REQ-017 FADING: level increments by 1 every FADE_FRAMES vblank rising edges; on reaching level 2 go to DIMMED.
REQ-018 DIMMED: hold level at maximum; frame counter stops (no wrap).
REQ-019 Any state->RUN in the cycle after pause goes low; level returns to 0 in that same cycle; counters cleared.
REQ-020 Level increases SHALL take effect only on a vblank rising edge (no mid-frame change).
REQ-021 Pause button edge and vblank edge in the same cycle: pause edge wins; the vblank edge is not counted.
REQ-022 Shading per 4-bit channel c: level 0 -> c; level 1 -> c - (c>>2); level 2 -> c>>1; no overflow, result 4 bits.
REQ-023 rgb_out SHALL be registered, exactly one clk latency from rgb_in, applied every cycle including blanking.
REQ-024 dimmed = (level != 0), registered alongside rgb_out.

Reset
REQ-025 On reset_n low: user-pause flag 0, previous-button register 0, state RUN, level 0, counters 0, pause 0, dimmed 0, rgb_out 12'h000.
REQ-026 Reset mid-fade SHALL return to RUN immediately; a held pause_btn at reset release SHALL NOT toggle pause.

Configuration
REQ-027 Macro PAUSE_DIM_FADE_EN defined: FADING state and level 1 present, stepwise fade per REQ-017.
REQ-028 PAUSE_DIM_FADE_EN undefined: FADING state and FADE_FRAMES unused; PAUSED goes directly to DIMMED at level 2 (half brightness).

Structure
REQ-029 Package pause_dim_pkg SHALL hold the state enum, the 2-bit level typedef, and level constants LVL_FULL/LVL_3Q/LVL_HALF.
REQ-030 Sub-module pause_dim_shade SHALL hold the combinational per-channel shade of REQ-022, instantiated three times.

Verification
REQ-031 pause_btn pulse, rgb_in=12'hFFF -> pause=1 one cycle later; rgb_out stays 12'hFFF; state PAUSED.
REQ-032 DIM_FRAMES=4, FADE_FRAMES=2, fade build, rgb_in=12'hF84 -> after 4 vblank edges rgb_out=12'hC63, after 2 more 12'h742, dimmed=1.
REQ-033 Same in non-fade build -> after 4 vblank edges rgb_out=12'h742 directly; no 12'hC63 ever observed.
REQ-034 Second pause_btn pulse while DIMMED -> next cycle pause=0, state RUN; rgb_out=rgb_in one cycle later.
REQ-035 pause_req held high with pause_btn idle -> pause=1 and dimming proceeds; pause_req low -> RUN, level 0.
REQ-036 reset_n asserted during FADING with pause_btn held high -> all outputs zero; after release no toggle until a new rising edge.

Source files
------------

// File: rtl/pause_dim_pkg.sv
// Shared types and constants for the pause/dim block: FSM states,
// the 2-bit shade level and the three defined shade levels.
package pause_dim_pkg;

  typedef enum logic [1:0] {
    RUN,
    PAUSED,
    FADING,
    DIMMED
  } state_t;

  typedef logic [1:0] level_t;

  localparam level_t LVL_FULL = 2'd0;
  localparam level_t LVL_3Q   = 2'd1;
  localparam level_t LVL_HALF = 2'd2;

  localparam int FRAME_CNT_W = 16;
  localparam int FADE_CNT_W  = 8;

endpackage

// File: rtl/pause_dim_shade.sv
// Combinational shade of one 4-bit colour channel. Level 0 passes the
// channel through, level 1 gives roughly three quarters, level 2 half.
module pause_dim_shade
  import pause_dim_pkg::*;
(
  input  logic [3:0] chan_in,
  input  level_t     level,
  output logic [3:0] chan_out
);

  // Pick the scaled channel value for the current level; never overflows
  // because both scaled forms are at most the input value.
  always_comb begin
    chan_out = chan_in;
    case (level)
      LVL_3Q:   chan_out = chan_in - (chan_in >> 2);
      LVL_HALF: chan_out = chan_in >> 1;
      default:  chan_out = chan_in;
    endcase
  end

endmodule

// File: rtl/pause_dim.sv
// Pause control and screen dimming for a video core. The user pause
// button toggles pause, an external request forces it, and after a
// number of paused frames the picture is darkened.
// Build option: define PAUSE_DIM_FADE_EN for a stepwise fade through a
// three-quarter level; without it the picture drops straight to half.
module pause_dim
  import pause_dim_pkg::*;
#(
  parameter int DIM_FRAMES  = 600,
  parameter int FADE_FRAMES = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pause_btn,
  input  logic        pause_req,
  input  logic        vblank,
  input  logic [11:0] rgb_in,
  output logic [11:0] rgb_out,
  output logic        pause,
  output logic        dimmed
);

  if (DIM_FRAMES < 1 || DIM_FRAMES > 65535) begin : g_bad_dim_frames
    $error("pause_dim: DIM_FRAMES must be in 1..65535");
  end

  if (FADE_FRAMES < 1 || FADE_FRAMES > 255) begin : g_bad_fade_frames
    $error("pause_dim: FADE_FRAMES must be in 1..255");
  end

  localparam logic [FRAME_CNT_W-1:0] DIM_COUNT = FRAME_CNT_W'(DIM_FRAMES);

  logic edge_valid;
  logic btn_prev;
  logic vblank_prev;
  logic user_pause;
  logic user_pause_next;
  logic btn_rise;
  logic vblank_rise;
  logic vblank_count;

  state_t state;
  state_t state_next;
  level_t level;
  level_t level_next;
  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic [FRAME_CNT_W-1:0] frame_cnt_next;

`ifdef PAUSE_DIM_FADE_EN
  localparam logic [FADE_CNT_W-1:0] FADE_COUNT = FADE_CNT_W'(FADE_FRAMES);
  logic [FADE_CNT_W-1:0] fade_cnt;
  logic [FADE_CNT_W-1:0] fade_cnt_next;
`endif

  logic [11:0] rgb_shaded;

  // edge_valid stays low for the first cycle after reset so a button
  // already held at release is taken as the old level, not a new press.
  assign btn_rise        = edge_valid & pause_btn & ~btn_prev;
  assign vblank_rise     = edge_valid & vblank & ~vblank_prev;
  assign vblank_count    = vblank_rise & ~btn_rise;
  assign user_pause_next = user_pause ^ btn_rise;

  // Edge-detect history, user pause toggle and the registered pause output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_valid  <= 1'b0;
      btn_prev    <= 1'b0;
      vblank_prev <= 1'b0;
      user_pause  <= 1'b0;
      pause       <= 1'b0;
    end else begin
      edge_valid  <= 1'b1;
      btn_prev    <= pause_btn;
      vblank_prev <= vblank;
      user_pause  <= user_pause_next;
      pause       <= user_pause_next | pause_req;
    end
  end

  // FSM state, shade level and frame counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RUN;
      level     <= LVL_FULL;
      frame_cnt <= '0;
`ifdef PAUSE_DIM_FADE_EN
      fade_cnt  <= '0;
`endif
    end else begin
      state     <= state_next;
      level     <= level_next;
      frame_cnt <= frame_cnt_next;
`ifdef PAUSE_DIM_FADE_EN
      fade_cnt  <= fade_cnt_next;
`endif
    end
  end

  // Next-state logic; levels only ever rise on a counted vblank edge, and
  // dropping pause returns to RUN at full brightness from any state.
  always_comb begin
    state_next     = state;
    level_next     = level;
    frame_cnt_next = frame_cnt;
`ifdef PAUSE_DIM_FADE_EN
    fade_cnt_next  = fade_cnt;
`endif
    if (!pause) begin
      state_next     = RUN;
      level_next     = LVL_FULL;
      frame_cnt_next = '0;
`ifdef PAUSE_DIM_FADE_EN
      fade_cnt_next  = '0;
`endif
    end else begin
      case (state)
        RUN: begin
          state_next     = PAUSED;
          level_next     = LVL_FULL;
          frame_cnt_next = '0;
`ifdef PAUSE_DIM_FADE_EN
          fade_cnt_next  = '0;
`endif
        end
        PAUSED: begin
          if (vblank_count) begin
            frame_cnt_next = frame_cnt + 1'b1;
            if (frame_cnt_next == DIM_COUNT) begin
`ifdef PAUSE_DIM_FADE_EN
              state_next    = FADING;
              level_next    = LVL_3Q;
              fade_cnt_next = '0;
`else
              state_next    = DIMMED;
              level_next    = LVL_HALF;
`endif
            end
          end
        end
`ifdef PAUSE_DIM_FADE_EN
        FADING: begin
          if (vblank_count) begin
            fade_cnt_next = fade_cnt + 1'b1;
            if (fade_cnt_next == FADE_COUNT) begin
              fade_cnt_next = '0;
              level_next    = level + 1'b1;
              if (level_next == LVL_HALF) begin
                state_next = DIMMED;
              end
            end
          end
        end
`endif
        DIMMED: begin
          level_next = LVL_HALF;
        end
        default: begin
          state_next = RUN;
          level_next = LVL_FULL;
        end
      endcase
    end
  end

  pause_dim_shade u_shade_r (
    .chan_in  (rgb_in[11:8]),
    .level    (level),
    .chan_out (rgb_shaded[11:8])
  );

  pause_dim_shade u_shade_g (
    .chan_in  (rgb_in[7:4]),
    .level    (level),
    .chan_out (rgb_shaded[7:4])
  );

  pause_dim_shade u_shade_b (
    .chan_in  (rgb_in[3:0]),
    .level    (level),
    .chan_out (rgb_shaded[3:0])
  );

  // Registered pixel output and dim flag, updated every cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_out <= 12'h000;
      dimmed  <= 1'b0;
    end else begin
      rgb_out <= rgb_shaded;
      dimmed  <= (level != LVL_FULL);
    end
  end

endmodule

// File: tb/tb_pause_dim.sv
// Directed bench for pause_dim with DIM_FRAMES=4 and FADE_FRAMES=2.
// Expected pixels follow the PAUSE_DIM_FADE_EN build option.
module tb_pause_dim;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pause_btn;
  logic        pause_req;
  logic        vblank;
  logic [11:0] rgb_in;
  logic [11:0] rgb_out;
  logic        pause;
  logic        dimmed;

  int assert_count = 0;
  int fail_count   = 0;

`ifdef PAUSE_DIM_FADE_EN
  localparam logic [11:0] EXP_STEP1 = 12'hC63;
`else
  localparam logic [11:0] EXP_STEP1 = 12'h742;
`endif

  pause_dim #(
    .DIM_FRAMES  (4),
    .FADE_FRAMES (2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pause_btn (pause_btn),
    .pause_req (pause_req),
    .vblank    (vblank),
    .rgb_in    (rgb_in),
    .rgb_out   (rgb_out),
    .pause     (pause),
    .dimmed    (dimmed)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Hard stop in case the directed sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected end of sequence");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [11:0] observed,
                              input logic [11:0] expected);
    assert_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic vblank_pulse(input int n);
    for (int i = 0; i < n; i++) begin
      vblank = 1'b1;
      tick(1);
      vblank = 1'b0;
      tick(1);
    end
  endtask

  task automatic btn_pulse();
    pause_btn = 1'b1;
    tick(1);
    pause_btn = 1'b0;
    tick(1);
  endtask

  // Directed sequence covering reset, pause, fade, resume and reset release.
  initial begin
    reset_n   = 1'b0;
    pause_btn = 1'b0;
    pause_req = 1'b0;
    vblank    = 1'b0;
    rgb_in    = 12'hFFF;
    tick(2);
    check_output("reset_rgb", rgb_out, 12'h000);
    check_output("reset_pause", 12'(pause), 12'h000);
    check_output("reset_dimmed", 12'(dimmed), 12'h000);

    reset_n = 1'b1;
    tick(1);
    check_output("run_pass", rgb_out, 12'hFFF);
    rgb_in = 12'h5A3;
    tick(1);
    check_output("run_latency", rgb_out, 12'h5A3);
    rgb_in = 12'hFFF;

    pause_btn = 1'b1;
    tick(1);
    check_output("btn_pause_on", 12'(pause), 12'h001);
    check_output("btn_rgb_full", rgb_out, 12'hFFF);
    pause_btn = 1'b0;
    tick(2);
    check_output("paused_rgb_full", rgb_out, 12'hFFF);
    check_output("paused_not_dim", 12'(dimmed), 12'h000);

    rgb_in = 12'hF84;
    vblank_pulse(3);
    check_output("three_frames_rgb", rgb_out, 12'hF84);
    check_output("three_frames_dim", 12'(dimmed), 12'h000);
    vblank_pulse(1);
    check_output("dim_start_rgb", rgb_out, EXP_STEP1);
    check_output("dim_start_flag", 12'(dimmed), 12'h001);
    vblank_pulse(1);
    check_output("fade_hold_rgb", rgb_out, EXP_STEP1);
    vblank_pulse(1);
    check_output("fade_half_rgb", rgb_out, 12'h742);
    check_output("fade_half_flag", 12'(dimmed), 12'h001);
    rgb_in = 12'hFFF;
    tick(1);
    check_output("half_white", rgb_out, 12'h777);
    rgb_in = 12'hF84;
    vblank_pulse(3);
    tick(1);
    check_output("dimmed_hold", rgb_out, 12'h742);

    pause_btn = 1'b1;
    tick(1);
    check_output("btn_pause_off", 12'(pause), 12'h000);
    pause_btn = 1'b0;
    tick(2);
    check_output("resume_rgb", rgb_out, 12'hF84);
    check_output("resume_dim", 12'(dimmed), 12'h000);

    pause_req = 1'b1;
    tick(1);
    check_output("req_pause_on", 12'(pause), 12'h001);
    tick(1);
    vblank_pulse(3);
    pause_btn = 1'b1;
    vblank    = 1'b1;
    tick(1);
    pause_btn = 1'b0;
    vblank    = 1'b0;
    tick(2);
    check_output("coincide_rgb", rgb_out, 12'hF84);
    check_output("coincide_dim", 12'(dimmed), 12'h000);
    check_output("coincide_pause", 12'(pause), 12'h001);
    vblank_pulse(1);
    check_output("req_dim_rgb", rgb_out, EXP_STEP1);
    vblank_pulse(2);
    check_output("req_half_rgb", rgb_out, 12'h742);
    btn_pulse();
    check_output("req_still_paused", 12'(pause), 12'h001);
    check_output("req_still_dim", rgb_out, 12'h742);
    pause_req = 1'b0;
    tick(1);
    check_output("req_pause_off", 12'(pause), 12'h000);
    tick(2);
    check_output("req_resume_rgb", rgb_out, 12'hF84);
    check_output("req_resume_dim", 12'(dimmed), 12'h000);

    btn_pulse();
    vblank_pulse(4);
    check_output("pre_reset_rgb", rgb_out, EXP_STEP1);
    reset_n   = 1'b0;
    pause_btn = 1'b1;
    #1;
    check_output("midfade_reset_rgb", rgb_out, 12'h000);
    check_output("midfade_reset_pause", 12'(pause), 12'h000);
    check_output("midfade_reset_dim", 12'(dimmed), 12'h000);
    tick(2);
    reset_n = 1'b1;
    tick(3);
    check_output("held_btn_no_toggle", 12'(pause), 12'h000);
    check_output("held_btn_rgb", rgb_out, 12'hF84);
    check_output("held_btn_dim", 12'(dimmed), 12'h000);
    pause_btn = 1'b0;
    tick(1);
    pause_btn = 1'b1;
    tick(1);
    check_output("new_press_pause", 12'(pause), 12'h001);
    pause_btn = 1'b0;
    tick(1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
